mips_multicycle_ctrl: RTL and testbench
=======================================

MIPS_MULTICYCLE_CTRL -- requirements
Module: mips_multicycle_ctrl

Interface
REQ-001 The block SHALL have parameter WAIT_LIMIT, default 15, giving the maximum consecutive memory wait cycles before timeout.
REQ-002 clk  input  1  single clock; all state SHALL change on its rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 opcode  input  6  instruction-register bits [31:26]; sampled only in DECODE.
REQ-005 mem_ready  input  1  memory access complete this cycle.
REQ-006 pc_write, pc_write_cond, ir_write  output  1 each  PC update, PC update on branch-taken, IR load.
REQ-007 mem_read, mem_write, iord  output  1 each  memory strobes; iord=1 selects the ALU-out address.
REQ-008 reg_write, reg_dst, mem_to_reg  output  1 each  register-file write, rd/rt select, memory/ALU writeback select.
REQ-009 alu_src_a  output  1 (0=PC, 1=A); alu_src_b  output  2 (0=B, 1=const 4, 2=sign-ext imm, 3=imm<<2).
REQ-010 alu_op  output  2 (0=add, 1=sub, 2=funct-decoded); pc_src  output  2 (0=ALU, 1=ALUOut, 2=jump target).
REQ-011 halted  output  1  controller stopped; err_timeout  output  1  sticky memory-timeout flag.

Function
REQ-012 States SHALL be FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, REX, RWB, BEQ, ADDIEX, ADDIWB, JMP, HALT.
REQ-013 FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=1, alu_op=0, pc_src=0; ir_write and pc_write SHALL assert only in the cycle mem_ready=1, which then moves to DECODE.
REQ-014 DECODE: alu_src_a=0, alu_src_b=3, alu_op=0 (branch target precompute), then dispatch on opcode.
REQ-015 Dispatch: 0x23 lw and 0x2B sw go to MEMADR; 0x00 R-type goes to REX; 0x04 beq goes to BEQ; 0x08 addi goes to ADDIEX; 0x02 j goes to JMP; any other opcode follows REQ-032.
REQ-016 MEMADR: alu_src_a=1, alu_src_b=2, alu_op=0; then MEMRD for lw, MEMWR for sw.
REQ-017 MEMRD: mem_read=1, iord=1; it SHALL wait for mem_ready, then go to MEMWB.
REQ-018 MEMWB: reg_write=1, reg_dst=0, mem_to_reg=1; then FETCH.
REQ-019 MEMWR: mem_write=1, iord=1; it SHALL wait for mem_ready, then go to FETCH.
REQ-020 REX: alu_src_a=1, alu_src_b=0, alu_op=2; then RWB. RWB: reg_write=1, reg_dst=1, mem_to_reg=0; then FETCH.
REQ-021 BEQ: alu_src_a=1, alu_src_b=0, alu_op=1, pc_src=1, pc_write_cond=1; then FETCH.
REQ-022 ADDIEX: alu_src_a=1, alu_src_b=2, alu_op=0; then ADDIWB. ADDIWB: reg_write=1, reg_dst=0, mem_to_reg=0; then FETCH.
REQ-023 JMP: pc_write=1, pc_src=2; then FETCH.
REQ-024 Outputs SHALL be Moore-decoded from state, except the FETCH ir_write/pc_write gating on mem_ready; every output not listed for a state SHALL be 0.
REQ-025 A wait counter SHALL clear on entry to FETCH, MEMRD and MEMWR, and SHALL increment each wait cycle with mem_ready=0.
REQ-026 When the counter reaches WAIT_LIMIT with mem_ready still 0, the FSM SHALL go to HALT and set err_timeout.
REQ-027 mem_ready=1 in the same cycle as the limit is reached SHALL complete the access normally with no error.
REQ-028 HALT SHALL be absorbing: halted=1, all strobes 0; only reset exits it.
REQ-029 mem_ready SHALL be ignored in states with no memory strobe.

Reset
REQ-030 Asserting rst (low) SHALL immediately, without waiting for clk, force state to FETCH, clear the wait counter, clear err_timeout and halted, and drive all strobes to 0; this applies mid-access.
REQ-031 After deassertion, the first rising edge SHALL begin FETCH with mem_read=1.

Configuration
REQ-032 With ILLEGAL_TRAP_EN defined, an unlisted opcode in DECODE SHALL go to HALT with halted=1; without it, an unlisted opcode SHALL return to FETCH as a NOP.

Verification
REQ-033 addi (0x08) with mem_ready tied high -> FETCH, DECODE, ADDIEX, ADDIWB, FETCH; reg_write=1 only in ADDIWB; 4 cycles per instruction.
REQ-034 j (0x02) -> pc_write=1 with pc_src=2 exactly one cycle, in the 3rd cycle; lw -> 5 cycles, with mem_to_reg=1 in MEMWB.
REQ-035 FETCH with mem_ready low for 3 cycles -> ir_write pulses once, on the 4th cycle; the FSM remains in FETCH meanwhile.
REQ-036 WAIT_LIMIT=15 with mem_ready held low in MEMRD -> HALT after 15 wait cycles, err_timeout=1; mem_ready=1 on the 15th wait cycle -> no error.
REQ-037 Opcode 0x3F -> HALT with ILLEGAL_TRAP_EN defined, FETCH without it.
REQ-038 rst pulled low mid-MEMWR -> mem_write=0 before the next clk edge; after release, FETCH with err_timeout=0.

Source files
------------

// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl -- multicycle MIPS control FSM (lw, sw, R-type, beq,
// addi, j) with a bounded memory-wait timeout.
//
// Ports:
//   clk            single clock, all state changes on its rising edge
//   rst            asynchronous active-low reset
//   opcode[5:0]    IR[31:26], sampled only in DECODE
//   mem_ready      memory access completes this cycle
//   pc_write, pc_write_cond, ir_write          PC / IR update strobes
//   mem_read, mem_write, iord                  memory strobes (iord=1: ALUOut addr)
//   reg_write, reg_dst, mem_to_reg             register-file writeback control
//   alu_src_a, alu_src_b[1:0], alu_op[1:0]     datapath ALU control
//   pc_src[1:0]                                PC source mux
//   halted         controller stopped (timeout or trapped opcode)
//   err_timeout    sticky memory-timeout flag
//
// Parameter WAIT_LIMIT: memory wait cycles tolerated before timeout.
// Optional macro ILLEGAL_TRAP_EN: unlisted opcodes halt instead of acting
// as NOPs.
module mips_multicycle_ctrl #(
  parameter int WAIT_LIMIT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       ir_write,
  output logic       mem_read,
  output logic       mem_write,
  output logic       iord,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_src,
  output logic       halted,
  output logic       err_timeout
);

  localparam int CW = $clog2(WAIT_LIMIT + 1);
  localparam logic [CW-1:0] LIM_M1 = CW'(WAIT_LIMIT - 1);

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
    REX, RWB, BEQ, ADDIEX, ADDIWB, JMP, HALT
  } st_t;

  // fetch marks FETCH; ir_write/pc_write there are gated by mem_ready.
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       fetch;
    logic       mem_read;
    logic       mem_write;
    logic       iord;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
    logic       halted;
  } ctl_t;

  st_t           state, nxt;
  ctl_t          ctl;
  logic [CW-1:0] cnt;
  logic          run;     // low until the first edge after reset release
  logic          is_sw;   // lw/sw choice captured in DECODE
  logic          wait_st, timeout;

  function automatic ctl_t dec(input st_t s);
    ctl_t c;
    c = '0;
    case (s)
      FETCH:  begin c.fetch = 1'b1; c.mem_read = 1'b1; c.alu_src_b = 2'd1; end
      DECODE: c.alu_src_b = 2'd3;
      MEMADR: begin c.alu_src_a = 1'b1; c.alu_src_b = 2'd2; end
      MEMRD:  begin c.mem_read = 1'b1; c.iord = 1'b1; end
      MEMWB:  begin c.reg_write = 1'b1; c.mem_to_reg = 1'b1; end
      MEMWR:  begin c.mem_write = 1'b1; c.iord = 1'b1; end
      REX:    begin c.alu_src_a = 1'b1; c.alu_op = 2'd2; end
      RWB:    begin c.reg_write = 1'b1; c.reg_dst = 1'b1; end
      BEQ:    begin
        c.alu_src_a = 1'b1; c.alu_op = 2'd1;
        c.pc_src = 2'd1; c.pc_write_cond = 1'b1;
      end
      ADDIEX: begin c.alu_src_a = 1'b1; c.alu_src_b = 2'd2; end
      ADDIWB: c.reg_write = 1'b1;
      JMP:    begin c.pc_write = 1'b1; c.pc_src = 2'd2; end
      HALT:   c.halted = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

  // Timeout fires on the WAIT_LIMIT-th consecutive not-ready cycle; a ready
  // in that same cycle wins and completes the access.
  assign wait_st = (state == FETCH) || (state == MEMRD) || (state == MEMWR);
  assign timeout = wait_st && !mem_ready && (cnt == LIM_M1);

  always_comb begin
    nxt = state;
    case (state)
      FETCH:  if (mem_ready) nxt = DECODE; else if (timeout) nxt = HALT;
      DECODE: begin
        case (opcode)
          6'h23, 6'h2B: nxt = MEMADR;
          6'h00:        nxt = REX;
          6'h04:        nxt = BEQ;
          6'h08:        nxt = ADDIEX;
          6'h02:        nxt = JMP;
`ifdef ILLEGAL_TRAP_EN
          default:      nxt = HALT;
`else
          default:      nxt = FETCH;
`endif
        endcase
      end
      MEMADR: nxt = is_sw ? MEMWR : MEMRD;
      MEMRD:  if (mem_ready) nxt = MEMWB; else if (timeout) nxt = HALT;
      MEMWB:  nxt = FETCH;
      MEMWR:  if (mem_ready) nxt = FETCH; else if (timeout) nxt = HALT;
      REX:    nxt = RWB;
      RWB:    nxt = FETCH;
      BEQ:    nxt = FETCH;
      ADDIEX: nxt = ADDIWB;
      ADDIWB: nxt = FETCH;
      JMP:    nxt = FETCH;
      HALT:   nxt = HALT;
      default: nxt = FETCH;
    endcase
  end

  // Outputs are registered from the next state, so reset can clear them
  // immediately while the state register already sits in FETCH.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= FETCH;
      ctl         <= '0;
      cnt         <= '0;
      run         <= 1'b0;
      is_sw       <= 1'b0;
      err_timeout <= 1'b0;
    end else if (!run) begin
      run   <= 1'b1;
      state <= FETCH;
      ctl   <= dec(FETCH);
      cnt   <= '0;
    end else begin
      state <= nxt;
      ctl   <= dec(nxt);
      if (state == DECODE) is_sw <= (opcode == 6'h2B);
      if (timeout) err_timeout <= 1'b1;
      if (nxt != state)               cnt <= '0;
      else if (wait_st && !mem_ready) cnt <= cnt + CW'(1);
    end
  end

  assign ir_write      = ctl.fetch & mem_ready;
  assign pc_write      = ctl.pc_write | (ctl.fetch & mem_ready);
  assign pc_write_cond = ctl.pc_write_cond;
  assign mem_read      = ctl.mem_read;
  assign mem_write     = ctl.mem_write;
  assign iord          = ctl.iord;
  assign reg_write     = ctl.reg_write;
  assign reg_dst       = ctl.reg_dst;
  assign mem_to_reg    = ctl.mem_to_reg;
  assign alu_src_a     = ctl.alu_src_a;
  assign alu_src_b     = ctl.alu_src_b;
  assign alu_op        = ctl.alu_op;
  assign pc_src        = ctl.pc_src;
  assign halted        = ctl.halted;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl. Output vector layout:
// {pc_write,pc_write_cond,ir_write,mem_read,mem_write,iord,reg_write,
//  reg_dst,mem_to_reg,alu_src_a,alu_src_b[1:0],alu_op[1:0],pc_src[1:0],halted}
module tb_mips_multicycle_ctrl;

  logic       clk, rst, mem_ready;
  logic [5:0] opcode;
  logic       pc_write, pc_write_cond, ir_write, mem_read, mem_write, iord;
  logic       reg_write, reg_dst, mem_to_reg, alu_src_a, halted, err_timeout;
  logic [1:0] alu_src_b, alu_op, pc_src;
  logic [16:0] sig;
  int n_chk = 0, n_err = 0;

  //                          pw pc iw mr mw io rw rd mr as asb aop psr h
  localparam logic [16:0] Z  = 17'b0;
  localparam logic [16:0] FR = 17'b1_0_1_1_0_0_0_0_0_0_01_00_00_0; // fetch, ready
  localparam logic [16:0] FW = 17'b0_0_0_1_0_0_0_0_0_0_01_00_00_0; // fetch, waiting
  localparam logic [16:0] DC = 17'b0_0_0_0_0_0_0_0_0_0_11_00_00_0;
  localparam logic [16:0] MA = 17'b0_0_0_0_0_0_0_0_0_1_10_00_00_0; // MEMADR/ADDIEX
  localparam logic [16:0] MR = 17'b0_0_0_1_0_1_0_0_0_0_00_00_00_0;
  localparam logic [16:0] MB = 17'b0_0_0_0_0_0_1_0_1_0_00_00_00_0;
  localparam logic [16:0] MW = 17'b0_0_0_0_1_1_0_0_0_0_00_00_00_0;
  localparam logic [16:0] RX = 17'b0_0_0_0_0_0_0_0_0_1_00_10_00_0;
  localparam logic [16:0] RB = 17'b0_0_0_0_0_0_1_1_0_0_00_00_00_0;
  localparam logic [16:0] BQ = 17'b0_1_0_0_0_0_0_0_0_1_00_01_01_0;
  localparam logic [16:0] AB = 17'b0_0_0_0_0_0_1_0_0_0_00_00_00_0;
  localparam logic [16:0] JP = 17'b1_0_0_0_0_0_0_0_0_0_00_00_10_0;
  localparam logic [16:0] HT = 17'b0_0_0_0_0_0_0_0_0_0_00_00_00_1;

  mips_multicycle_ctrl #(.WAIT_LIMIT(15)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .ir_write(ir_write),
    .mem_read(mem_read), .mem_write(mem_write), .iord(iord),
    .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_src(pc_src), .halted(halted), .err_timeout(err_timeout)
  );

  assign sig = {pc_write, pc_write_cond, ir_write, mem_read, mem_write, iord,
                reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op,
                pc_src, halted};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive inputs just after the edge, check mid-cycle.
  task automatic cyc(input string tag, input logic rdy, input logic [5:0] op,
                     input logic [16:0] exp);
    @(posedge clk); #1;
    mem_ready = rdy;
    opcode    = op;
    #1;
    chk(tag, {15'd0, sig}, {15'd0, exp});
  endtask

  task automatic rst_pulse();
    @(posedge clk); #3;
    rst = 1'b0;
    #1;
    chk("rst_sig", {15'd0, sig}, 32'd0);
    chk("rst_err", {31'd0, err_timeout}, 32'd0);
    @(posedge clk); #3;
    rst = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; mem_ready = 1'b0; opcode = 6'h00;
    #3;
    chk("reset_sig", {15'd0, sig}, {15'd0, Z});
    chk("reset_err", {31'd0, err_timeout}, 32'd0);
    @(posedge clk); #1; mem_ready = 1'b1; #1;
    chk("reset_hold", {15'd0, sig}, {15'd0, Z});
    @(posedge clk); #3; rst = 1'b1; #1;
    chk("pre_edge", {15'd0, sig}, {15'd0, Z});

    // addi: 4 cycles, reg_write only in ADDIWB
    cyc("addi_f", 1, 6'h3F, FR);
    cyc("addi_d", 1, 6'h08, DC);
    cyc("addi_ex", 1, 6'h3F, MA);
    cyc("addi_wb", 1, 6'h3F, AB);
    // j: pc_write with pc_src=2 in the 3rd cycle
    cyc("j_f", 1, 6'h3F, FR);
    cyc("j_d", 1, 6'h02, DC);
    cyc("j_jmp", 1, 6'h3F, JP);
    // lw: 5 cycles
    cyc("lw_f", 1, 6'h3F, FR);
    cyc("lw_d", 1, 6'h23, DC);
    cyc("lw_adr", 1, 6'h3F, MA);
    cyc("lw_rd", 1, 6'h3F, MR);
    cyc("lw_wb", 1, 6'h3F, MB);
    // sw with two wait cycles
    cyc("sw_f", 1, 6'h3F, FR);
    cyc("sw_d", 1, 6'h2B, DC);
    cyc("sw_adr", 0, 6'h3F, MA);
    cyc("sw_w0", 0, 6'h3F, MW);
    cyc("sw_w1", 0, 6'h3F, MW);
    cyc("sw_w2", 1, 6'h3F, MW);
    // R-type
    cyc("r_f", 1, 6'h3F, FR);
    cyc("r_d", 1, 6'h00, DC);
    cyc("r_ex", 1, 6'h3F, RX);
    cyc("r_wb", 1, 6'h3F, RB);
    // beq
    cyc("beq_f", 1, 6'h3F, FR);
    cyc("beq_d", 1, 6'h04, DC);
    cyc("beq_x", 1, 6'h3F, BQ);
    // fetch waits 3 cycles, ir_write on the 4th
    cyc("fw_0", 0, 6'h3F, FW);
    cyc("fw_1", 0, 6'h3F, FW);
    cyc("fw_2", 0, 6'h3F, FW);
    cyc("fw_3", 1, 6'h3F, FR);
    // unlisted opcode
    cyc("ill_d", 1, 6'h3F, DC);
`ifdef ILLEGAL_TRAP_EN
    cyc("ill_halt", 1, 6'h3F, HT);
    rst_pulse();
`else
    cyc("ill_nop", 1, 6'h3F, FR);
    cyc("nop_d", 1, 6'h08, DC);
    cyc("nop_ex", 1, 6'h3F, MA);
    cyc("nop_wb", 1, 6'h3F, AB);
`endif
    // ready on the 15th wait cycle: completes normally
    cyc("lim_f", 1, 6'h3F, FR);
    cyc("lim_d", 1, 6'h23, DC);
    cyc("lim_adr", 0, 6'h3F, MA);
    for (int i = 0; i < 14; i++) cyc("lim_wait", 0, 6'h3F, MR);
    cyc("lim_last", 1, 6'h3F, MR);
    cyc("lim_wb", 1, 6'h3F, MB);
    chk("lim_err", {31'd0, err_timeout}, 32'd0);
    // 15 wait cycles: timeout into HALT
    cyc("to_f", 1, 6'h3F, FR);
    cyc("to_d", 1, 6'h23, DC);
    cyc("to_adr", 0, 6'h3F, MA);
    for (int i = 0; i < 15; i++) cyc("to_wait", 0, 6'h3F, MR);
    cyc("to_halt0", 1, 6'h23, HT);
    chk("to_err", {31'd0, err_timeout}, 32'd1);
    cyc("to_halt1", 1, 6'h08, HT);
    cyc("to_halt2", 0, 6'h02, HT);
    chk("to_err_sticky", {31'd0, err_timeout}, 32'd1);
    // asynchronous reset out of HALT
    rst = 1'b0; #1;
    chk("halt_rst_sig", {15'd0, sig}, 32'd0);
    chk("halt_rst_err", {31'd0, err_timeout}, 32'd0);
    @(posedge clk); #3; rst = 1'b1;
    // reset in the middle of MEMWR
    cyc("mw_f", 1, 6'h3F, FR);
    cyc("mw_d", 1, 6'h2B, DC);
    cyc("mw_adr", 0, 6'h3F, MA);
    cyc("mw_wr", 0, 6'h3F, MW);
    rst = 1'b0; #1;
    chk("mw_rst_mem_write", {31'd0, mem_write}, 32'd0);
    chk("mw_rst_sig", {15'd0, sig}, 32'd0);
    @(posedge clk); #3; rst = 1'b1;
    cyc("post_f", 1, 6'h3F, FR);
    chk("post_err", {31'd0, err_timeout}, 32'd0);
    cyc("post_d", 1, 6'h00, DC);
    cyc("post_ex", 1, 6'h3F, RX);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
